// File: rtl/perm_pkg.sv
// Shared types and helpers for the bit-permutation stream stage.
package perm_pkg;

  // Upper bounds for the packed identity-map helper; WIDTH must not exceed MAX_WIDTH.
  localparam int MAX_WIDTH = 64;
  localparam int MAX_IDXW  = 6;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } perm_state_e;

  // Entry i holds i, packed at [i*MAX_IDXW +: MAX_IDXW]; callers slice the low bits they need.
  function automatic logic [MAX_WIDTH*MAX_IDXW-1:0] identity_map(input int width);
    logic [MAX_WIDTH*MAX_IDXW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) m[i*MAX_IDXW +: MAX_IDXW] = MAX_IDXW'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/perm_xbar.sv
// Combinational bit crossbar: each output bit picks one input bit by its map entry.
module perm_xbar #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH*IDXW-1:0] map_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic [WIDTH-1:0]      data_o
);

  // One WIDTH:1 mux per output bit; an entry matching no input yields 0.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (map_i[i*IDXW +: IDXW] == IDXW'(j)) data_o[i] = data_i[j];
      end
    end
  end

endmodule

// File: rtl/perm_stream_stage.sv
// Registered, runtime-configurable bit-permutation stage with valid/ready on both sides.
// A shadow map is written one entry per cycle; it is copied into the active map only
// after the output register has drained, so no beat ever sees a half-updated map.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal streaming; cfg_commit requests a map swap
//   DRAIN | input stalled, waiting for the held output beat to leave
//   SWAP  | single cycle: active map <- shadow map
module perm_stream_stage
  import perm_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [IDXW-1:0]  cfg_src,
  input  logic             cfg_commit,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [MAX_WIDTH*MAX_IDXW-1:0] ID_MAP = identity_map(WIDTH);

  perm_state_e                state_q, state_d;
  logic [WIDTH-1:0][IDXW-1:0] shadow_q;
  logic [WIDTH-1:0][IDXW-1:0] active_q;
  logic                       out_valid_q;
  logic [WIDTH-1:0]           out_data_q;
  logic                       cfg_err_q;
  logic [WIDTH-1:0]           perm_data;
  logic                       accept;
  logic                       bad_wr;

  // Index and source are compared one bit wider so non-power-of-two widths catch codes >= WIDTH.
  assign bad_wr = ({1'b0, cfg_idx} >= (IDXW+1)'(WIDTH)) ||
                  ({1'b0, cfg_src} >= (IDXW+1)'(WIDTH));

  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q == DRAIN) || (state_q == SWAP);

  perm_xbar #(.WIDTH(WIDTH)) u_xbar (
    .map_i  (active_q),
    .data_i (in_data),
    .data_o (perm_data)
  );

  // Next-state logic; DRAIN exits as soon as the held beat is leaving this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_commit) state_d = DRAIN;
      DRAIN:   if (!out_valid_q || out_ready) state_d = SWAP;
      SWAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Map storage; SWAP copies the pre-write shadow, so a same-cycle write lands only in shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        shadow_q[i] <= ID_MAP[i*MAX_IDXW +: IDXW];
        active_q[i] <= ID_MAP[i*MAX_IDXW +: IDXW];
      end
    end else begin
      if (cfg_we && !bad_wr) shadow_q[cfg_idx] <= cfg_src;
      if (state_q == SWAP)   active_q <= shadow_q;
    end
  end

  // Sticky error flag for out-of-range config writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cfg_err_q <= 1'b0;
    else if (cfg_we && bad_wr) cfg_err_q <= 1'b1;
  end

  // Output register: load on accept, drop on consume, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= perm_data;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perm_stream_stage.sv
// Directed bench for perm_stream_stage: an 8-bit instance for the data/FSM checks and
// a 6-bit instance for out-of-range config writes.
module tb_perm_stream_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       a_cfg_we, a_cfg_commit, a_cfg_err;
  logic [2:0] a_cfg_idx, a_cfg_src;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_in_data, a_out_data;

  // WIDTH=6 instance
  logic       b_cfg_we, b_cfg_commit, b_cfg_err;
  logic [2:0] b_cfg_idx, b_cfg_src;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [5:0] b_in_data, b_out_data;

  int tests = 0;
  int fails = 0;

  perm_stream_stage #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx), .cfg_src(a_cfg_src),
    .cfg_commit(a_cfg_commit), .cfg_err(a_cfg_err),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy)
  );

  perm_stream_stage #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_src(b_cfg_src),
    .cfg_commit(b_cfg_commit), .cfg_err(b_cfg_err),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input int idx, input int src);
    a_cfg_we = 1'b1; a_cfg_idx = 3'(idx); a_cfg_src = 3'(src);
    step();
    a_cfg_we = 1'b0;
  endtask

  task automatic wr6(input int idx, input int src);
    b_cfg_we = 1'b1; b_cfg_idx = 3'(idx); b_cfg_src = 3'(src);
    step();
    b_cfg_we = 1'b0;
  endtask

  task automatic commit8();
    int n;
    a_cfg_commit = 1'b1;
    step();
    a_cfg_commit = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin step(); n++; end
    chk("commit8_done", a_busy, 0);
  endtask

  task automatic commit6();
    int n;
    b_cfg_commit = 1'b1;
    step();
    b_cfg_commit = 1'b0;
    n = 0;
    while (b_busy && n < 20) begin step(); n++; end
    chk("commit6_done", b_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_cfg_we = 0; a_cfg_idx = 0; a_cfg_src = 0; a_cfg_commit = 0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_cfg_we = 0; b_cfg_idx = 0; b_cfg_src = 0; b_cfg_commit = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    step(); step();

    // Reset state
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data",  a_out_data, 8'h00);
    chk("rst_cfg_err",   a_cfg_err, 0);
    chk("rst_busy",      a_busy, 0);
    chk("rst_cfg_err6",  b_cfg_err, 0);
    rst_n = 1'b1;
    step();

    // Identity map, back-to-back
    a_out_ready = 1; a_in_valid = 1; a_in_data = 8'hA5;
    chk("id_in_ready0", a_in_ready, 1);
    step();
    chk("id_valid0", a_out_valid, 1);
    chk("id_data0",  a_out_data, 8'hA5);
    a_in_data = 8'h3C;
    chk("id_in_ready1", a_in_ready, 1);
    step();
    chk("id_valid1", a_out_valid, 1);
    chk("id_data1",  a_out_data, 8'h3C);
    a_in_valid = 0;
    step();
    chk("id_drained", a_out_valid, 0);

    // Reversal map with explicit busy timing
    for (int i = 0; i < 8; i++) wr8(i, 7 - i);
    a_cfg_commit = 1;
    step();
    a_cfg_commit = 0;
    chk("rev_busy_drain", a_busy, 1);
    chk("rev_ready_drain", a_in_ready, 0);
    step();
    chk("rev_busy_swap", a_busy, 1);
    step();
    chk("rev_busy_run", a_busy, 0);
    chk("rev_ready_run", a_in_ready, 1);
    a_in_valid = 1; a_in_data = 8'h01;
    step();
    chk("rev_data0", a_out_data, 8'h80);
    a_in_data = 8'hC3;
    step();
    chk("rev_data1", a_out_data, 8'hC3);
    a_in_valid = 0;
    step();

    // Mixed map {in[7:6], in[4], in[5], in[0], in[3:1]}
    wr8(7, 7); wr8(6, 6); wr8(5, 4); wr8(4, 5);
    wr8(3, 0); wr8(2, 3); wr8(1, 2); wr8(0, 1);
    commit8();
    a_in_valid = 1; a_in_data = 8'h01;
    step();
    chk("mix_data0", a_out_data, 8'h08);
    a_in_data = 8'h10;
    step();
    chk("mix_data1", a_out_data, 8'h20);
    a_in_data = 8'h02;
    step();
    chk("mix_data2", a_out_data, 8'h01);
    a_in_valid = 0;
    step();

    // Commit under backpressure; shadow loaded with rotate-left-by-one
    for (int i = 0; i < 8; i++) wr8(i, (i + 7) % 8);
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h01;
    step();
    a_in_valid = 0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_held_valid", a_out_valid, 1);
    chk("bp_held_data",  a_out_data, 8'h08);
    chk("bp_held_ready", a_in_ready, 0);
    a_in_valid = 1; a_in_data = 8'h02; a_cfg_commit = 1;
    step();
    a_cfg_commit = 0;
    chk("bp_busy_drain", a_busy, 1);
    chk("bp_ready_drain", a_in_ready, 0);
    step(); step();
    chk("bp_still_drain", a_busy, 1);
    chk("bp_data_stable", a_out_data, 8'h08);
    a_out_ready = 1;
    chk("bp_ready_forced0", a_in_ready, 0);
    step();
    a_out_ready = 0;
    chk("bp_valid_taken", a_out_valid, 0);
    chk("bp_busy_swap", a_busy, 1);
    step();
    chk("bp_busy_run", a_busy, 0);
    chk("bp_ready_run", a_in_ready, 1);
    a_out_ready = 1; a_in_data = 8'h81;
    step();
    chk("bp_new_map", a_out_data, 8'h03);
    a_in_valid = 0;
    step();

    // Out-of-range writes on the 6-bit instance
    for (int i = 0; i < 6; i++) wr6(i, 5 - i);
    commit6();
    b_out_ready = 1; b_in_valid = 1; b_in_data = 6'h01;
    step();
    chk("w6_rev", b_out_data, 6'h20);
    b_in_valid = 0;
    chk("w6_err_clean", b_cfg_err, 0);
    wr6(6, 0);
    chk("w6_err_idx", b_cfg_err, 1);
    wr6(0, 7);
    chk("w6_err_src", b_cfg_err, 1);
    wr6(3, 2);
    chk("w6_err_sticky", b_cfg_err, 1);
    commit6();
    b_in_valid = 1; b_in_data = 6'h20;
    step();
    chk("w6_map_kept0", b_out_data, 6'h01);
    b_in_data = 6'h04;
    step();
    chk("w6_map_kept1", b_out_data, 6'h08);
    b_in_valid = 0;
    step();

    // Reset while holding a beat in DRAIN
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h55;
    step();
    a_in_valid = 0; a_cfg_commit = 1;
    step();
    a_cfg_commit = 0;
    chk("rm_pre_busy", a_busy, 1);
    chk("rm_pre_valid", a_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_valid", a_out_valid, 0);
    chk("rm_async_busy",  a_busy, 0);
    step();
    rst_n = 1'b1;
    chk("rm_cfg_err6", b_cfg_err, 0);
    a_out_ready = 1; a_in_valid = 1; a_in_data = 8'hA5;
    step();
    chk("rm_identity", a_out_data, 8'hA5);
    chk("rm_valid", a_out_valid, 1);
    a_in_valid = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
